// File: rtl/mem_model_pkg.sv
// Shared definitions for the burst memory responder: controller states and
// the default geometry/latency constants used by the top level.
// Imported by burst_mem_responder; rr_arbiter is fully parameter-driven.
package mem_model_pkg;

   localparam int DEF_NUM_CH      = 2;
   localparam int DEF_BEAT_W      = 64;
   localparam int DEF_BURST_LEN   = 4;
   localparam int DEF_DEPTH_LINES = 512;
   localparam int DEF_PAGE_LINES  = 8;
   localparam int DEF_MISS_CYCLES = 10;
   localparam int DEF_HIT_CYCLES  = 5;

   // Controller states: wait for a request, pick a channel, model access
   // latency, then stream the line one beat per cycle.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_BURST = 2'd3
   } state_e;

   // Width for a counter that must hold values 0..max_val, never below 2 bits
   // so that small compare constants stay representable.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 2) ? 2 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// Grant is combinational from req and the pointer; the pointer moves to the
// channel after the winner only when the grant is accepted.
module rr_arbiter #(
   parameter int NUM_CH = 2,
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              accept,
   output logic [NUM_CH-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              grant_vld
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W:0]   cand;

   // Scan channels starting at the pointer, wrapping, and take the first requester.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_CH)) begin
            cand = cand - (IDX_W+1)'(NUM_CH);
         end
         if (!grant_vld && req[cand[IDX_W-1:0]]) begin
            grant_vld                = 1'b1;
            grant_idx                = cand[IDX_W-1:0];
            grant[cand[IDX_W-1:0]]   = 1'b1;
         end
      end
   end

   // Advance the pointer past the accepted winner so it has lowest priority next.
   always_comb begin
      ptr_d = ptr_q;
      if (accept && grant_vld) begin
         if (grant_idx == IDX_W'(NUM_CH - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx + IDX_W'(1);
         end
      end
   end

   // Pointer register; channel 0 has first priority after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/burst_mem_responder.sv
// Multi-channel line memory model: arbitrates channels round-robin and
// streams BURST_LEN beats after a page hit/miss latency. One transfer at a
// time; requesters hold their request until the last beat (no other stall).
module burst_mem_responder
   import mem_model_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int BEAT_W      = DEF_BEAT_W,
   parameter int BURST_LEN   = DEF_BURST_LEN,
   parameter int DEPTH_LINES = DEF_DEPTH_LINES,
   parameter int PAGE_LINES  = DEF_PAGE_LINES,
   parameter int MISS_CYCLES = DEF_MISS_CYCLES,
   parameter int HIT_CYCLES  = DEF_HIT_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_read,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*32-1:0]     ch_addr,
   input  logic [NUM_CH*BEAT_W-1:0] ch_wdata,
   output logic [NUM_CH*BEAT_W-1:0] ch_rdata,
   output logic [NUM_CH-1:0]        ch_resp,
   output logic                     err
);

   localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LINE_BYTES = BURST_LEN * BEAT_W / 8;
   localparam int OFS_W      = $clog2(LINE_BYTES);
   localparam int LINE_W     = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
   localparam int PG_SHIFT   = $clog2(PAGE_LINES);
   localparam int BEAT_IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int MEM_WORDS  = DEPTH_LINES * BURST_LEN;
   localparam int MEM_AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int MAX_LAT    = (MISS_CYCLES > HIT_CYCLES) ? MISS_CYCLES : HIT_CYCLES;
   localparam int CNT_W      = cnt_width(MAX_LAT);

   // Backing store, one word per beat; zero at time zero, never cleared by reset.
   logic [BEAT_W-1:0] mem [MEM_WORDS] = '{default: '0};

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    gnt_q, gnt_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                wr_q, wr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BEAT_IDX_W-1:0] beat_q, beat_d;
   logic [LINE_W-1:0]   open_page_q, open_page_d;
   logic                open_vld_q, open_vld_d;
   logic                err_q, err_d;

   logic [NUM_CH-1:0]   conflict;
   logic [NUM_CH-1:0]   eligible;
   logic [NUM_CH-1:0]   arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_vld;
   logic [31:0]         arb_addr;
   logic [LINE_W-1:0]   arb_line;
   logic [LINE_W-1:0]   arb_page;
   logic [CNT_W-1:0]    arb_lat;
   logic [MEM_AW-1:0]   mem_addr;
   logic [BEAT_W-1:0]   wdata_sel;

   // A channel asking for both directions at once is malformed: flag it and
   // leave it out of arbitration so the others still make progress.
   assign conflict = ch_read & ch_write;
   assign eligible = ch_read ^ ch_write;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (eligible),
      .accept    (state_q == ST_ARB),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_vld (arb_vld)
   );

   // Decode the winner's address: drop the in-line byte offset, wrap to the
   // storage depth, and derive the page used for the hit/miss decision.
   always_comb begin
      arb_addr = ch_addr[arb_idx*32 +: 32];
      arb_line = arb_addr[OFS_W +: LINE_W];
      arb_page = arb_line >> PG_SHIFT;
      arb_lat  = (open_vld_q && (open_page_q == arb_page)) ? CNT_W'(HIT_CYCLES)
                                                           : CNT_W'(MISS_CYCLES);
   end

   // Current beat location in the backing store and the granted write beat.
   always_comb begin
      mem_addr  = MEM_AW'(line_q) * MEM_AW'(BURST_LEN) + MEM_AW'(beat_q);
      wdata_sel = ch_wdata[gnt_q*BEAT_W +: BEAT_W];
   end

   // Transfer sequencing: arbitrate, count down the access latency, stream beats.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      line_d      = line_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      beat_d      = beat_q;
      open_page_d = open_page_q;
      open_vld_d  = open_vld_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (|(ch_read | ch_write)) begin
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            if (|conflict) begin
               err_d = 1'b1;
            end
            if (arb_vld) begin
               gnt_d       = arb_idx;
               line_d      = arb_line;
               wr_d        = ch_write[arb_idx];
               open_page_d = arb_page;
               open_vld_d  = 1'b1;
               cnt_d       = arb_lat;
               beat_d      = '0;
               // A one-cycle latency puts the first beat right after ARB.
               state_d     = (arb_lat == CNT_W'(1)) ? ST_BURST : ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(2)) begin
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (beat_q == BEAT_IDX_W'(BURST_LEN - 1)) begin
               beat_d  = '0;
               state_d = ST_IDLE;
            end else begin
               beat_d = beat_q + BEAT_IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Beat strobe and read data go only to the granted channel; others see zero.
   always_comb begin
      ch_resp  = '0;
      ch_rdata = '0;
      if (state_q == ST_BURST) begin
         ch_resp[gnt_q] = 1'b1;
         if (!wr_q) begin
            ch_rdata[gnt_q*BEAT_W +: BEAT_W] = mem[mem_addr];
         end
      end
   end

   assign err = err_q;

   // Control registers; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         line_q      <= '0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         beat_q      <= '0;
         open_page_q <= '0;
         open_vld_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         line_q      <= line_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         beat_q      <= beat_d;
         open_page_q <= open_page_d;
         open_vld_q  <= open_vld_d;
         err_q       <= err_d;
      end
   end

   // Write beats land on the edge where the strobe is high; a reset on that
   // edge suppresses the write so beats already stored are all that remain.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == ST_BURST) && wr_q) begin
         mem[mem_addr] <= wdata_sel;
      end
   end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder with a beat scoreboard.
// Expected beats are queued when a request is raised and checked as strobes appear.
module tb_burst_mem_responder;

   localparam int NCH = 2;
   localparam int BW  = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    ch_read;
   logic [NCH-1:0]    ch_write;
   logic [NCH*32-1:0] ch_addr;
   logic [NCH*BW-1:0] ch_wdata;
   logic [NCH*BW-1:0] ch_rdata;
   logic [NCH-1:0]    ch_resp;
   logic              err;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int          ch;
      bit          chk;
      logic [63:0] dat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   burst_mem_responder #(
      .NUM_CH      (NCH),
      .BEAT_W      (BW),
      .BURST_LEN   (4),
      .DEPTH_LINES (512),
      .PAGE_LINES  (8),
      .MISS_CYCLES (10),
      .HIT_CYCLES  (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_read  (ch_read),
      .ch_write (ch_write),
      .ch_addr  (ch_addr),
      .ch_wdata (ch_wdata),
      .ch_rdata (ch_rdata),
      .ch_resp  (ch_resp),
      .err      (err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pat(input logic [63:0] base, input int i);
      return base + 64'(i);
   endfunction

   task automatic push(input int ch, input bit chkd, input logic [63:0] d);
      exp_t e;
      e.ch  = ch;
      e.chk = chkd;
      e.dat = d;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every strobe must match the next queued beat.
   always @(negedge clk) begin
      if (|ch_resp) begin
         chk("resp_onehot", 64'($countones(ch_resp)), 64'd1);
         for (int c = 0; c < NCH; c++) begin
            if (ch_resp[c]) begin
               exp_t e;
               if (sb.size() > 0) begin
                  e = sb.pop_front();
               end else begin
                  e.ch = -1; e.chk = 1'b0; e.dat = '0;
               end
               chk("beat_ch", 64'(c), 64'(e.ch));
               if (e.chk) chk("rdata", ch_rdata[c*BW +: BW], e.dat);
            end else begin
               chk("other_rdata_zero", ch_rdata[c*BW +: BW], 64'd0);
            end
         end
      end
   end

   // One transfer on one channel. Called at a negedge with the DUT idle.
   // exp_lat > 0 checks first-beat latency; rst_beat >= 0 pulses reset on that beat.
   task automatic xfer(input int ch, input bit wr, input logic [31:0] addr,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [63:0] d3,
                       input int exp_lat, input int rst_beat);
      logic [63:0] d [4];
      int n;
      int nbeats;
      d = '{d0, d1, d2, d3};
      nbeats = (rst_beat >= 0) ? rst_beat + 1 : 4;
      for (int i = 0; i < nbeats; i++) push(ch, !wr, d[i]);
      ch_addr[ch*32 +: 32] = addr;
      if (wr) ch_write[ch] = 1'b1; else ch_read[ch] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ch_resp[ch] && n < 200);
      // Request seen at the next edge (ARB), first beat exp_lat edges later.
      if (exp_lat > 0) chk("first_beat_latency", 64'(n), 64'(exp_lat + 1));
      for (int k = 0; k < nbeats; k++) begin
         chk("beat_contiguous", 64'(ch_resp[ch]), 64'd1);
         if (wr) ch_wdata[ch*BW +: BW] = d[k];
         if (k == rst_beat) rst = 1'b1;
         @(negedge clk);
      end
      chk("resp_after_burst", 64'(ch_resp), 64'd0);
      rst = 1'b0;
      ch_read[ch]  = 1'b0;
      ch_write[ch] = 1'b0;
      ch_wdata[ch*BW +: BW] = '0;
   endtask

   initial begin
      int nb;
      rst      = 1'b1;
      ch_read  = '0;
      ch_write = '0;
      ch_addr  = '0;
      ch_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_resp", 64'(ch_resp), 64'd0);
      chk("reset_rdata", ch_rdata[BW-1:0] | ch_rdata[2*BW-1:BW], 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Cold read: page miss, storage starts at zero.
      xfer(0, 1'b0, 32'h40, 64'd0, 64'd0, 64'd0, 64'd0, 10, -1);
      // Write then read back in the same page: hits.
      xfer(0, 1'b1, 32'h40, pat(64'hA0, 0), pat(64'hA0, 1), pat(64'hA0, 2), pat(64'hA0, 3), 5, -1);
      xfer(0, 1'b0, 32'h40, pat(64'hA0, 0), pat(64'hA0, 1), pat(64'hA0, 2), pat(64'hA0, 3), 5, -1);
      // Address wrap: 0x4000 is line 512, which aliases line 0.
      xfer(0, 1'b1, 32'h0, pat(64'hB0, 0), pat(64'hB0, 1), pat(64'hB0, 2), pat(64'hB0, 3), 5, -1);
      xfer(0, 1'b0, 32'h4000, pat(64'hB0, 0), pat(64'hB0, 1), pat(64'hB0, 2), pat(64'hB0, 3), 5, -1);

      // Reset again so the round-robin pointer starts at channel 0.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_err_clear", 64'(err), 64'd0);

      // Both channels request continuously: expect ch0, ch1, ch0, ch1.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) push(0, 1'b1, pat(64'hA0, i));
         for (int i = 0; i < 4; i++) push(1, 1'b1, pat(64'hB0, i));
      end
      ch_addr = {32'h0, 32'h40};
      ch_read = 2'b11;
      nb = 0;
      for (int t = 0; t < 400 && nb < 16; t++) begin
         @(negedge clk);
         if (|ch_resp) nb++;
      end
      ch_read = '0;
      chk("rr_beats_seen", 64'(nb), 64'd16);
      chk("rr_err", 64'(err), 64'd0);
      repeat (2) @(negedge clk);
      chk("rr_sb_drained", 64'(sb.size()), 64'd0);

      // ch1 asks read+write together: flagged and skipped, ch0 proceeds.
      for (int i = 0; i < 4; i++) push(0, 1'b1, pat(64'hA0, i));
      ch_addr  = {32'h0, 32'h40};
      ch_read  = 2'b11;
      ch_write = 2'b10;
      nb = 0;
      for (int t = 0; t < 200 && nb < 4; t++) begin
         @(negedge clk);
         if (ch_resp[0]) nb++;
      end
      ch_read[0] = 1'b0;
      chk("conflict_ch0_beats", 64'(nb), 64'd4);
      repeat (20) @(negedge clk);
      ch_read  = '0;
      ch_write = '0;
      chk("conflict_err", 64'(err), 64'd1);
      @(negedge clk);
      chk("conflict_err_sticky", 64'(err), 64'd1);

      // Reset during beat 2 of a write to line 0x40 (holding A0..A3).
      xfer(0, 1'b1, 32'h40, pat(64'hC0, 0), pat(64'hC0, 1), pat(64'hC0, 2), pat(64'hC0, 3), 5, 2);
      chk("post_rst_err", 64'(err), 64'd0);
      @(negedge clk);
      xfer(0, 1'b0, 32'h40, pat(64'hC0, 0), pat(64'hC0, 1), pat(64'hA0, 2), pat(64'hA0, 3), 10, -1);

      repeat (2) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
